// File: rtl/snd_cond_pkg.sv
// -----------------------------------------------------------------------------
// snd_cond_pkg
// Shared definitions for the sound-output conditioning path: FSM state type,
// default widths, saturation bounds and the unity volume code. Imported by
// snd_out_conditioner and snd_sat16 (the saturator is also used by the mixer).
// -----------------------------------------------------------------------------
package snd_cond_pkg;

  // Default sample width and fractional bits of the filter state.
  localparam int SND_W_IN  = 16;
  localparam int SND_FRAC  = 8;
  // Two guard bits above the sample cover the DC-blocker's gain near Nyquist.
  localparam int SND_W_INT = SND_W_IN + SND_FRAC + 2;

  // Volume is unsigned Q1.7: 128 is unity, products are shifted down by 7.
  localparam int         VOL_FRAC  = 7;
  localparam logic [7:0] VOL_UNITY = 8'd128;

  // Output saturation bounds for a signed 16-bit sample.
  localparam logic signed [15:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  // One state per processing step; LPF exists in the type even when the
  // low-pass is not built, so state encodings are identical in both builds.
  typedef enum logic [2:0] {
    IDLE,
    DCB,
    LPF,
    GAIN,
    OUT
  } snd_cond_state_t;

  // Internal filter-state width for a given sample width and fraction.
  function automatic int int_width(input int w_in, input int frac);
    return w_in + frac + 2;
  endfunction

endpackage

// File: rtl/snd_sat16.sv
// -----------------------------------------------------------------------------
// snd_sat16
// Combinational saturator: wide signed value down to a signed 16-bit sample.
// Ports:
//   din   in  W_I  signed wide value
//   dout  out 16   signed value clamped to [SAT_MIN, SAT_MAX]
//   ovf   out 1    high when din did not fit and was clamped
// -----------------------------------------------------------------------------
module snd_sat16
  import snd_cond_pkg::*;
#(
  parameter int W_I = SND_W_INT
) (
  input  logic signed [W_I-1:0] din,
  output logic signed [15:0]    dout,
  output logic                  ovf
);

  // The value fits when every bit from the output sign bit upward agrees.
  logic [W_I-16:0] top_bits;
  assign top_bits = din[W_I-1:15];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ovf  = !((&top_bits) || !(|top_bits));
    dout = din[15:0];
    if (ovf) begin
      dout = din[W_I-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/snd_out_conditioner.sv
// -----------------------------------------------------------------------------
// snd_out_conditioner
// Post-processing of the YM3526 sound-board sample: DC-blocking high-pass,
// optional one-pole low-pass, Q1.7 volume with saturation. Produces a held
// signed sample plus a one-cycle strobe for the audio mixer.
//
// Build option: define SND_LPF_EN to include the low-pass stage (latency 4);
// without it the gain stage takes the DC-blocker output directly (latency 3).
//
// Ports:
//   clk         in  1     system clock
//   RESETn      in  1     synchronous active-low reset
//   snd_in      in  W_IN  signed sample from the sound board
//   sample_in   in  1     sample strobe; a rising edge marks a new sample
//   vol         in  8     unsigned gain, Q1.7 (128 = unity)
//   mute        in  1     forces the output to 0, filters keep running
//   snd_out     out W_IN  signed conditioned sample, held between strobes
//   sample_out  out 1     one-cycle pulse when snd_out updates
//   clip        out 1     pulse with sample_out when saturation occurred
//   busy        out 1     high while the FSM is not idle
// -----------------------------------------------------------------------------
module snd_out_conditioner
  import snd_cond_pkg::*;
#(
  parameter int W_IN      = 16,
  parameter int FRAC      = 8,
  parameter int DCB_SHIFT = 8,
  parameter int LPF_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   RESETn,
  input  logic signed [W_IN-1:0] snd_in,
  input  logic                   sample_in,
  input  logic [7:0]             vol,
  input  logic                   mute,
  output logic signed [W_IN-1:0] snd_out,
  output logic                   sample_out,
  output logic                   clip,
  output logic                   busy
);

  localparam int W_INT = int_width(W_IN, FRAC);

  // ---------------------------------------------------------------------------
  // Edge detect and FSM
  // ---------------------------------------------------------------------------
  logic            sample_q;
  logic            edge_det;
  logic            pending;
  snd_cond_state_t state, state_next;
  logic            do_dcb, do_lpf, do_gain, do_out;

  assign edge_det = sample_in & ~sample_q;
  assign busy     = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_dcb     = 1'b0;
    do_lpf     = 1'b0;
    do_gain    = 1'b0;
    do_out     = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) state_next = DCB;
      end
      DCB: begin
        do_dcb = 1'b1;
`ifdef SND_LPF_EN
        state_next = LPF;
`else
        state_next = GAIN;
`endif
      end
`ifdef SND_LPF_EN
      LPF: begin
        do_lpf     = 1'b1;
        state_next = GAIN;
      end
`endif
      GAIN: begin
        do_gain    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        do_out = 1'b1;
        // An edge landing in OUT itself is taken directly, without pending.
        state_next = (pending || edge_det) ? DCB : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [W_IN-1:0]  x_cur, x_prev;
  logic signed [W_INT-1:0] x_cur_w, x_prev_w;
  logic signed [W_INT-1:0] y_prev, y_next;
  logic signed [W_INT-1:0] f_in, f_int, vol_w, prod, prod_sh;
  logic signed [15:0]      sat_val;
  logic                    sat_ovf;
  logic signed [W_IN-1:0]  sat_reg;
  logic                    ovf_reg;

  assign x_cur_w  = {{(W_INT-W_IN){x_cur[W_IN-1]}}, x_cur};
  assign x_prev_w = {{(W_INT-W_IN){x_prev[W_IN-1]}}, x_prev};

  // y = x - x[-1] + y[-1]*(1 - 2^-DCB_SHIFT), all in FRAC-bit fixed point.
  assign y_next = (x_cur_w <<< FRAC) - (x_prev_w <<< FRAC)
                + y_prev - (y_prev >>> DCB_SHIFT);

`ifdef SND_LPF_EN
  logic signed [W_INT-1:0] z_prev, z_next;

  // The LPF state runs after DCB, so y_prev already holds this sample's y.
  assign z_next = z_prev + ((y_prev - z_prev) >>> LPF_SHIFT);
  assign f_in   = z_prev;

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      z_prev <= '0;
    end else if (do_lpf) begin
      z_prev <= z_next;
    end
  end
`else
  // LPF_SHIFT has no hardware to configure in this build.
  localparam int unused_lpf_shift = LPF_SHIFT;

  assign f_in = y_prev;
`endif

  // Integer part of the filter output times the unsigned Q1.7 volume.
  assign f_int   = f_in >>> FRAC;
  assign vol_w   = $signed({{(W_INT-8){1'b0}}, vol});
  assign prod    = f_int * vol_w;
  assign prod_sh = prod >>> VOL_FRAC;

  snd_sat16 #(
    .W_I (W_INT)
  ) u_sat (
    .din  (prod_sh),
    .dout (sat_val),
    .ovf  (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      sample_q   <= 1'b0;
      pending    <= 1'b0;
      x_cur      <= '0;
      x_prev     <= '0;
      y_prev     <= '0;
      sat_reg    <= '0;
      ovf_reg    <= 1'b0;
      snd_out    <= '0;
      sample_out <= 1'b0;
      clip       <= 1'b0;
    end else begin
      sample_q <= sample_in;

      // Latest sample wins: every edge re-captures, busy or not.
      if (edge_det) x_cur <= snd_in;

      if (do_out) begin
        pending <= 1'b0;
      end else if (edge_det && busy) begin
        pending <= 1'b1;
      end

      if (do_dcb) begin
        x_prev <= x_cur;
        y_prev <= y_next;
      end

      if (do_gain) begin
        sat_reg <= sat_val;
        ovf_reg <= sat_ovf;
      end

      sample_out <= do_out;
      clip       <= do_out & ovf_reg;
      if (do_out) begin
        snd_out <= mute ? '0 : sat_reg;
      end
    end
  end

endmodule
